sample_page_writer: RTL and testbench

Downstream stage of the sample packet generator. It collects the packets the generator writes, four at a time, into page-aligned 128-bit pages. Completed pages are queued in a small FIFO and issued to the memory interface over a valid/ready write port. It returns `pageFull` to the generator so that capture completion lands only on page boundaries, and it reports drain, overflow and sequencing status.

---
 rtl/sample_pkg.sv | 14 +
 rtl/page_fifo.sv | 41 ++++
 rtl/sample_page_writer.sv | 76 +++++++
 tb/tb_sample_page_writer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// sample_pkg: shared constants and page entry type for the sample page writer
package sample_pkg;
    localparam int SAMPLE_PACKET_WIDTH = 32;
    localparam int PACKETS_PER_PAGE = 4;
    localparam int MEMORY_CAPACITY = 2**27;
    localparam int PAGE_WIDTH = SAMPLE_PACKET_WIDTH * PACKETS_PER_PAGE;
    localparam int BYTES_PER_PAGE = PAGE_WIDTH / 8;
    localparam int ADDR_WIDTH = $clog2(MEMORY_CAPACITY);
    localparam int LANE_BITS = $clog2(PACKETS_PER_PAGE);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [PAGE_WIDTH-1:0] data;
    } page_t;
endpackage

// File: rtl/page_fifo.sv
// page_fifo: show-ahead shifting FIFO whose head is always entry 0
module page_fifo
    import sample_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  page_t din,
    output page_t dout,
    output logic  full,
    output logic  empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    page_t mem [DEPTH];
    logic [CW-1:0] count, count_n;
    logic [IW-1:0] wr_pos;
    logic do_push, do_pop;
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign wr_pos = IW'(count - CW'(do_pop));
    assign count_n = count + CW'(do_push) - CW'(do_pop);
    assign dout = mem[0];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
            empty <= 1'b1;
            full <= 1'b0;
        end else begin
            if (do_pop) for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            if (do_push) mem[wr_pos] <= din;
            count <= count_n;
            empty <= count_n == '0;
            full <= count_n == CW'(DEPTH);
        end
    end
endmodule

// File: rtl/sample_page_writer.sv
// sample_page_writer: assembles sample packets into pages and issues them to memory
module sample_page_writer
    import sample_pkg::*;
#(
    parameter int PAGE_FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           running,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket,
    input  logic [31:0]                    sample_number,
    input  logic                           write_enable,
    output logic                           pageFull,
    output logic                           mem_wr_valid,
    input  logic                           mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]          mem_wr_addr,
    output logic [PAGE_WIDTH-1:0]          mem_wr_data,
    output logic                           drained,
    output logic                           overflow,
    output logic                           seq_error,
    output logic [31:0]                    pages_written
);
    logic [PACKETS_PER_PAGE-1:0][SAMPLE_PACKET_WIDTH-1:0] lanes, lanes_n;
    logic [PACKETS_PER_PAGE-1:0] mask, mask_n;
    logic [LANE_BITS-1:0] lane, expected_lane;
    logic we, in_seq, close, pop, fifo_full, fifo_empty;
    page_t din, head;
    assign lane = sample_number[LANE_BITS-1:0];
    assign we = write_enable & running;
    assign in_seq = lane == expected_lane;
    // an out-of-sequence last lane restarts the mask instead of closing a partial page
    assign close = we & in_seq & (lane == LANE_BITS'(PACKETS_PER_PAGE - 1));
    assign pop = ~fifo_empty & mem_wr_ready;
    always_comb begin
        lanes_n = lanes;
        lanes_n[lane] = samplePacket;
        mask_n = !running ? '0 : !we ? mask : close ? '0
               : (in_seq ? mask : '0) | (PACKETS_PER_PAGE'(1) << lane);
        din.addr = ADDR_WIDTH'({sample_number[31:LANE_BITS], LANE_BITS'(0)} * 32'(SAMPLE_PACKET_WIDTH / 8));
        din.data = lanes_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            lanes <= '0;
            mask <= '0;
            expected_lane <= '0;
            pageFull <= 1'b1;
            overflow <= 1'b0;
            seq_error <= 1'b0;
            pages_written <= '0;
        end else begin
            if (we) lanes <= lanes_n;
            mask <= mask_n;
            pageFull <= mask_n == '0;
            expected_lane <= !running ? '0 : we ? lane + LANE_BITS'(1) : expected_lane;
            overflow <= (close & fifo_full & ~pop) | (overflow & ~start);
            seq_error <= (we & ~in_seq) | (seq_error & ~start);
            pages_written <= start ? '0 : pages_written + 32'(pop);
        end
    end
    page_fifo #(.DEPTH(PAGE_FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(close),
        .pop(pop),
        .din(din),
        .dout(head),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    assign mem_wr_valid = ~fifo_empty;
    assign mem_wr_addr = head.addr;
    assign mem_wr_data = head.data;
    assign drained = pageFull & fifo_empty;
endmodule

// File: tb/tb_sample_page_writer.sv
// tb_sample_page_writer: directed vector table plus multi-cycle sequences for sample_page_writer
module tb_sample_page_writer;
    logic clk = 1'b0;
    logic reset, start, running, write_enable, mem_wr_ready;
    logic [31:0] samplePacket, sample_number, pages_written;
    logic pageFull, mem_wr_valid, drained, overflow, seq_error;
    logic [26:0] mem_wr_addr;
    logic [127:0] mem_wr_data;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic run, we, rdy, st;
        logic [31:0] sn, pkt;
        logic pf, vld, dr, ovf, seq;
        logic [31:0] pw;
        logic [26:0] addr;
        logic [127:0] data;
    } vec_t;
    vec_t tbl[$];
    localparam logic [31:0] A = 32'hA000_0000, B = 32'hB000_0000, C = 32'hC000_0000, D = 32'hD000_0000;
    localparam logic [31:0] E = 32'hE000_0000, F = 32'hF000_0000, G = 32'h1100_0000, H = 32'h2200_0000;
    localparam logic [31:0] J = 32'h3300_0000, K = 32'h4400_0000, L = 32'h5500_0000, M = 32'h6600_0000;

    sample_page_writer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .running(running),
        .samplePacket(samplePacket),
        .sample_number(sample_number),
        .write_enable(write_enable),
        .pageFull(pageFull),
        .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .drained(drained),
        .overflow(overflow),
        .seq_error(seq_error),
        .pages_written(pages_written)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pg(input logic [31:0] t);
        return {t | 32'd3, t | 32'd2, t | 32'd1, t};
    endfunction

    function automatic vec_t v(input logic run, we, input logic [31:0] sn, pkt, input logic rdy, st,
                               pf, vld, dr, ovf, seq, input logic [31:0] pw, input logic [26:0] addr,
                               input logic [127:0] data);
        vec_t r;
        r.run = run; r.we = we; r.sn = sn; r.pkt = pkt; r.rdy = rdy; r.st = st;
        r.pf = pf; r.vld = vld; r.dr = dr; r.ovf = ovf; r.seq = seq; r.pw = pw; r.addr = addr; r.data = data;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic run, we, input logic [31:0] sn, pkt, input logic rdy, st);
        running = run;
        write_enable = we;
        sample_number = sn;
        samplePacket = pkt;
        mem_wr_ready = rdy;
        start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic page(input logic [31:0] base, t, input logic rdy, st_last);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, base + 32'(i), t | 32'(i), rdy, st_last && i == 3);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        running = 1'b0;
        write_enable = 1'b0;
        mem_wr_ready = 1'b0;
        sample_number = '0;
        samplePacket = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pageFull", pageFull, 1);
        chk("reset drained", drained, 1);
        chk("reset valid", mem_wr_valid, 0);
        chk("reset addr", mem_wr_addr, 0);
        chk("reset data", mem_wr_data, 0);
        chk("reset overflow", overflow, 0);
        chk("reset seq_error", seq_error, 0);
        chk("reset pages_written", pages_written, 0);
        reset = 1'b0;

        // run we sn pkt rdy st | pf vld dr ovf seq pw addr data
        tbl.push_back(v(1, 1, 0, A | 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 1, A | 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 2, A | 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 3, A | 3, 1, 0, 1, 1, 0, 0, 0, 0, 27'h0, pg(A)));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, B | 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 1, 1, B | 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 1, 3, B | 3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 1, 4, C | 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 1, 5, C | 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 1, 6, C | 2, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 1, 7, C | 3, 1, 0, 1, 1, 0, 0, 1, 1, 27'h10, pg(C)));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 2, 0, 0));
        tbl.push_back(v(1, 1, 8, D | 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(v(1, 1, 9, D | 1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 2, 0, 0));
        tbl.push_back(v(0, 1, 12, D | 4, 1, 0, 1, 0, 1, 0, 1, 2, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].run, tbl[i].we, tbl[i].sn, tbl[i].pkt, tbl[i].rdy, tbl[i].st);
            chk($sformatf("v%0d pageFull", i), pageFull, tbl[i].pf);
            chk($sformatf("v%0d valid", i), mem_wr_valid, tbl[i].vld);
            chk($sformatf("v%0d drained", i), drained, tbl[i].dr);
            chk($sformatf("v%0d overflow", i), overflow, tbl[i].ovf);
            chk($sformatf("v%0d seq_error", i), seq_error, tbl[i].seq);
            chk($sformatf("v%0d pages_written", i), pages_written, tbl[i].pw);
            if (tbl[i].vld) begin
                chk($sformatf("v%0d addr", i), mem_wr_addr, tbl[i].addr);
                chk($sformatf("v%0d data", i), mem_wr_data, tbl[i].data);
            end
        end

        page(32'h01FF_FFFC, E, 1'b1, 1'b0);
        chk("wrap0 valid", mem_wr_valid, 1);
        chk("wrap0 addr", mem_wr_addr, 27'h7FF_FFF0);
        chk("wrap0 data", mem_wr_data, pg(E));
        page(32'h0, F, 1'b1, 1'b0);
        chk("wrap1 valid", mem_wr_valid, 1);
        chk("wrap1 addr", mem_wr_addr, 27'h0);
        chk("wrap1 data", mem_wr_data, pg(F));
        chk("wrap1 pages_written", pages_written, 1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("wrap pages_written", pages_written, 2);
        chk("wrap seq_error", seq_error, 0);
        chk("wrap valid", mem_wr_valid, 0);

        page(32'd16, G, 1'b0, 1'b0);
        chk("bp0 valid", mem_wr_valid, 1);
        chk("bp0 addr", mem_wr_addr, 27'h40);
        page(32'd20, H, 1'b0, 1'b0);
        chk("bp1 addr held", mem_wr_addr, 27'h40);
        chk("bp1 data held", mem_wr_data, pg(G));
        chk("bp1 overflow", overflow, 0);
        page(32'd24, J, 1'b0, 1'b0);
        chk("bp2 overflow", overflow, 1);
        chk("bp2 addr held", mem_wr_addr, 27'h40);
        chk("bp2 data held", mem_wr_data, pg(G));
        cyc(1, 0, 0, 0, 1, 0);
        chk("bp pop1 valid", mem_wr_valid, 1);
        chk("bp pop1 addr", mem_wr_addr, 27'h50);
        chk("bp pop1 data", mem_wr_data, pg(H));
        chk("bp pop1 pages_written", pages_written, 3);
        cyc(1, 0, 0, 0, 1, 0);
        chk("bp pop2 valid", mem_wr_valid, 0);
        chk("bp pop2 pages_written", pages_written, 4);
        cyc(1, 0, 0, 0, 1, 0);
        chk("bp no third write", pages_written, 4);

        cyc(1, 0, 0, 0, 1, 1);
        chk("start overflow", overflow, 0);
        chk("start pages_written", pages_written, 0);

        page(32'd28, K, 1'b0, 1'b0);
        page(32'd32, L, 1'b0, 1'b0);
        chk("st+ovf pre overflow", overflow, 0);
        page(32'd36, M, 1'b0, 1'b1);
        chk("st+ovf overflow", overflow, 1);
        chk("st+ovf pages_written", pages_written, 0);

        cyc(1, 1, 32'd40, A, 1'b0, 1'b0);
        cyc(1, 1, 32'd41, A | 1, 1'b0, 1'b0);
        chk("mid pageFull", pageFull, 0);
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("midreset valid", mem_wr_valid, 0);
        chk("midreset pageFull", pageFull, 1);
        chk("midreset drained", drained, 1);
        chk("midreset overflow", overflow, 0);
        chk("midreset addr", mem_wr_addr, 0);
        chk("midreset data", mem_wr_data, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk("midreset no write", pages_written, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
